// File: rtl/router_reg_gen.sv
// Router packet register stage: forwards header/payload/parity bytes to the FIFO,
// absorbs bytes in a small skid buffer while the FIFO is full, and checks parity and length.
module router_reg_gen #(
  parameter int DW         = 8,
  parameter int SKID_DEPTH = 2,
  parameter int LEN_CHECK  = 1
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              pkt_valid,
  input  logic                              fifo_full,
  input  logic                              detect_add,
  input  logic                              lfd_state,
  input  logic                              ld_state,
  input  logic                              laf_state,
  input  logic                              full_state,
  input  logic                              rst_int_reg,
  input  logic [DW-1:0]                     data_in,
  output logic [DW-1:0]                     data_out,
  output logic                              dout_vld,
  output logic                              parity_done,
  output logic                              low_pkt_valid,
  output logic                              err,
  output logic                              len_err,
  output logic                              skid_overflow,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   skid_count
);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH+1);
  localparam int LW = DW - 2;

  logic [DW-1:0] header_q;
  logic [DW-1:0] int_parity;
  logic [DW-1:0] pkt_parity;
  logic [LW-1:0] pay_cnt;
  logic          parity_done_d;
  logic [DW-1:0] skid_mem [SKID_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          move, skid_empty, skid_full;
  logic          take, drop, push, pop, load_hdr, load_out;
  logic [DW-1:0] out_next;
  logic [DW-1:0] parity_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Skid entries always drain before the current input byte is forwarded.
  always_comb begin
    move        = !detect_add && !full_state;
    skid_empty  = (skid_count == '0);
    skid_full   = (skid_count == CW'(SKID_DEPTH));
    take        = move && ld_state && (!fifo_full || !skid_full);
    drop        = move && ld_state && fifo_full && skid_full;
    push        = take && (fifo_full || !skid_empty);
    pop         = move && !fifo_full && !skid_empty && (ld_state || laf_state);
    load_hdr    = move && lfd_state;
    load_out    = load_hdr || (take && !fifo_full) || pop;
    out_next    = data_in;
    if (load_hdr)
      out_next = header_q;
    else if (pop)
      out_next = skid_mem[rd_ptr];
    parity_next = int_parity;
    if (load_hdr)
      parity_next = int_parity ^ header_q;
    else if (take && pkt_valid)
      parity_next = int_parity ^ data_in;
  end

  assign dout_vld = load_out && resetn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      header_q      <= '0;
      int_parity    <= '0;
      pkt_parity    <= '0;
      pay_cnt       <= '0;
      parity_done_d <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      skid_count    <= '0;
      data_out      <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
      skid_overflow <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
    end else begin
      if (detect_add) begin
        if (pkt_valid) header_q <= data_in;
        int_parity    <= '0;
        pkt_parity    <= '0;
        pay_cnt       <= '0;
        parity_done   <= 1'b0;
        parity_done_d <= 1'b0;
        err           <= 1'b0;
        len_err       <= 1'b0;
        skid_overflow <= 1'b0;
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        skid_count    <= '0;
      end else begin
        if (load_out) data_out <= out_next;
        int_parity <= parity_next;
        if (take && pkt_valid && (pay_cnt != {LW{1'b1}}))
          pay_cnt <= pay_cnt + LW'(1);
        if (take && !pkt_valid) begin
          pkt_parity  <= data_in;
          parity_done <= 1'b1;
        end
        if (drop) skid_overflow <= 1'b1;
        if (push) begin
          skid_mem[wr_ptr] <= data_in;
          wr_ptr           <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)
          skid_count <= skid_count + CW'(1);
        else if (pop && !push)
          skid_count <= skid_count - CW'(1);
        parity_done_d <= parity_done;
        // Checks run once, on the cycle after parity_done first rises.
        if (parity_done && !parity_done_d) begin
          err     <= (int_parity != pkt_parity);
          len_err <= (LEN_CHECK != 0) && (pay_cnt != header_q[DW-1:2]);
        end
      end
      if (rst_int_reg)
        low_pkt_valid <= 1'b0;
      else if (take && !pkt_valid)
        low_pkt_valid <= 1'b1;
    end
  end
endmodule
